// File: rtl/cnn_pkg.sv
// Shared definitions for the 1-D convolution datapath.
//
// Holds the datapath geometry (sample width, input length, filter length),
// the derived memory address widths and the loader state encoding, so that
// the loader and the convolution controller agree on frame sizes without
// repeating the numbers.
package cnn_pkg;

    // Sample / tap data width
    localparam int T  = 16;
    // Input vector length (xmem depth)
    localparam int N  = 30;
    // Filter length (fmem depth)
    localparam int M  = 9;

    // Address widths for the two memories
    localparam int XA = $clog2(N);
    localparam int FA = $clog2(M);

    // Loader frame sequencing states
    typedef enum logic [1:0] {
        INIT = 2'd0,
        LOAD = 2'd1,
        CONV = 2'd2
    } loader_state_t;

endpackage

// File: rtl/load_counter.sv
// Saturating beat counter for one input-loader port.
//
// Counts accepted beats from 0 up to DEPTH and then holds there until
// cleared, so a port that has finished its frame can never wrap and
// overwrite memory location 0.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset, clears the count
//   en         one accepted beat this cycle
//   clr        synchronous clear for the next frame (wins over en)
//   count      current beat count, 0..DEPTH
//   full       count has reached DEPTH
//   full_next  count will be DEPTH after this cycle's beat is taken
module load_counter #(
    parameter int DEPTH = 9,
    parameter int W     = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         full,
    output logic         full_next
);

    localparam logic [W-1:0] FULL_VAL = W'(DEPTH);
    localparam logic [W-1:0] LAST_VAL = W'(DEPTH - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !full) begin
            count <= count + W'(1);
        end
    end

    assign full = (count == FULL_VAL);

    // Lets the FSM leave LOAD on the same edge as the final beat rather
    // than one cycle later.
    assign full_next = !clr && (full || (en && (count == LAST_VAL)));

endmodule

// File: rtl/input_loader.sv
// Input loader: upstream stage of the 1-D convolution datapath.
//
// Accepts N input samples and M filter taps on two independent
// valid/ready slave ports, writes them into xmem and fmem with zero
// latency, then raises conv_start and holds it until the convolution
// controller pulses conv_done, after which it re-arms for the next frame.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   s_data_in_x/s_valid_x/s_ready_x x sample stream
//   s_data_in_f/s_valid_f/s_ready_f filter tap stream
//   conv_done                       pulse from the convolution controller
//   conv_start                      both memories loaded, convolution may run
//   xmem_wr_en/addr/data            xmem write port
//   fmem_wr_en/addr/data            fmem write port
module input_loader #(
    parameter int T  = cnn_pkg::T,
    parameter int N  = cnn_pkg::N,
    parameter int M  = cnn_pkg::M,
    parameter int XA = $clog2(N),
    parameter int FA = $clog2(M)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [T-1:0]  s_data_in_x,
    input  logic          s_valid_x,
    output logic          s_ready_x,
    input  logic [T-1:0]  s_data_in_f,
    input  logic          s_valid_f,
    output logic          s_ready_f,
    input  logic          conv_done,
    output logic          conv_start,
    output logic          xmem_wr_en,
    output logic [XA-1:0] xmem_wr_addr,
    output logic [T-1:0]  xmem_wr_data,
    output logic          fmem_wr_en,
    output logic [FA-1:0] fmem_wr_addr,
    output logic [T-1:0]  fmem_wr_data
);

    import cnn_pkg::*;

    loader_state_t state;
    loader_state_t state_next;

    logic [XA:0] x_cnt;
    logic [FA:0] f_cnt;
    logic        x_full;
    logic        f_full;
    logic        x_full_next;
    logic        f_full_next;
    logic        frame_clr;

    // State register; an asynchronous reset abandons any partial frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. LOAD looks at the post-write counts so the move to
    // CONV happens on the edge of whichever port delivers its last beat.
    always_comb begin
        state_next = state;
        case (state)
            INIT: state_next = LOAD;
            LOAD: if (x_full_next && f_full_next) state_next = CONV;
            CONV: if (conv_done) state_next = LOAD;
            default: state_next = INIT;
        endcase
    end

    assign frame_clr = (state == CONV) && conv_done;

    // Readies come from registers only, so the upstream never sees a
    // valid-to-ready combinational path.
    assign s_ready_x  = (state == LOAD) && !x_full;
    assign s_ready_f  = (state == LOAD) && !f_full;

    assign xmem_wr_en   = s_valid_x && s_ready_x;
    assign xmem_wr_addr = x_cnt[XA-1:0];
    assign xmem_wr_data = s_data_in_x;

    assign fmem_wr_en   = s_valid_f && s_ready_f;
    assign fmem_wr_addr = f_cnt[FA-1:0];
    assign fmem_wr_data = s_data_in_f;

    // Decoded from state so reset drops it without waiting for a clock.
    assign conv_start = (state == CONV);

    load_counter #(
        .DEPTH (N),
        .W     (XA + 1)
    ) u_x_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (xmem_wr_en),
        .clr       (frame_clr),
        .count     (x_cnt),
        .full      (x_full),
        .full_next (x_full_next)
    );

    load_counter #(
        .DEPTH (M),
        .W     (FA + 1)
    ) u_f_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (fmem_wr_en),
        .clr       (frame_clr),
        .count     (f_cnt),
        .full      (f_full),
        .full_next (f_full_next)
    );

endmodule

// File: tb/tb_input_loader.sv
// Directed self-checking bench for input_loader.
//
// Walks through a full-rate frame, a CONV hold with beats still offered,
// a frame turnaround, a gapped frame ending in a simultaneous x/f finish
// with a stray conv_done, and asynchronous resets during LOAD and CONV.
module tb_input_loader;

    localparam int T  = 16;
    localparam int N  = 30;
    localparam int M  = 9;
    localparam int XA = 5;
    localparam int FA = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [T-1:0]  s_data_in_x;
    logic          s_valid_x;
    logic          s_ready_x;
    logic [T-1:0]  s_data_in_f;
    logic          s_valid_f;
    logic          s_ready_f;
    logic          conv_done;
    logic          conv_start;
    logic          xmem_wr_en;
    logic [XA-1:0] xmem_wr_addr;
    logic [T-1:0]  xmem_wr_data;
    logic          fmem_wr_en;
    logic [FA-1:0] fmem_wr_addr;
    logic [T-1:0]  fmem_wr_data;

    int assert_count = 0;
    int fail_count   = 0;

    input_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_data_in_x  (s_data_in_x),
        .s_valid_x    (s_valid_x),
        .s_ready_x    (s_ready_x),
        .s_data_in_f  (s_data_in_f),
        .s_valid_f    (s_valid_f),
        .s_ready_f    (s_ready_f),
        .conv_done    (conv_done),
        .conv_start   (conv_start),
        .xmem_wr_en   (xmem_wr_en),
        .xmem_wr_addr (xmem_wr_addr),
        .xmem_wr_data (xmem_wr_data),
        .fmem_wr_en   (fmem_wr_en),
        .fmem_wr_addr (fmem_wr_addr),
        .fmem_wr_data (fmem_wr_data)
    );

    always #5 clk = ~clk;

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of port inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic vx, input logic [T-1:0] dx,
                                 input logic vf, input logic [T-1:0] df,
                                 input logic done);
        s_valid_x   = vx;
        s_data_in_x = dx;
        s_valid_f   = vf;
        s_data_in_f = df;
        conv_done   = done;
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_rdy_x"}, s_ready_x, 1'b0);
        checkOutput({tag, "_rdy_f"}, s_ready_f, 1'b0);
        checkOutput({tag, "_wen_x"}, xmem_wr_en, 1'b0);
        checkOutput({tag, "_wen_f"}, fmem_wr_en, 1'b0);
    endtask

    // Full-rate frame: x every cycle, f for the first M cycles.
    task automatic fullRateFrame(input string tag);
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b1, T'(16'h1000 + i), 1'b1, T'(16'h2000 + i), 1'b0);
            checkOutput({tag, "_x_wen"}, xmem_wr_en, 1'b1);
            checkOutput({tag, "_x_addr"}, xmem_wr_addr, i);
            checkOutput({tag, "_x_data"}, xmem_wr_data, 16'h1000 + i);
            if (i < M) begin
                checkOutput({tag, "_f_wen"}, fmem_wr_en, 1'b1);
                checkOutput({tag, "_f_addr"}, fmem_wr_addr, i);
                checkOutput({tag, "_f_data"}, fmem_wr_data, 16'h2000 + i);
            end else begin
                checkOutput({tag, "_f_rdy_low"}, s_ready_f, 1'b0);
                checkOutput({tag, "_f_wen_low"}, fmem_wr_en, 1'b0);
            end
            checkOutput({tag, "_start_low"}, conv_start, 1'b0);
            step();
        end
    endtask

    initial begin
        int x_sent;
        int f_sent;
        int x_writes;
        int f_writes;
        int c;
        logic vx;
        logic vf;

        // Reset is asserted with valids already high: nothing may be written.
        reset_n = 1'b0;
        applyStimulus(1'b1, 16'h0, 1'b1, 16'h0, 1'b0);
        #2;
        checkOutput("reset_start", conv_start, 1'b0);
        checkIdle("reset");
        checkOutput("reset_x_addr", xmem_wr_addr, 0);
        checkOutput("reset_f_addr", fmem_wr_addr, 0);

        step();
        step();
        reset_n = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("init_rdy_x", s_ready_x, 1'b0);
        step();
        checkOutput("load_rdy_x", s_ready_x, 1'b1);
        checkOutput("load_rdy_f", s_ready_f, 1'b1);

        // Frame 1 at full rate; conv_start one cycle after the 30th x beat.
        $display("[TB] frame 1: full rate");
        fullRateFrame("f1");
        applyStimulus(1'b1, 16'hdead, 1'b1, 16'hbeef, 1'b0);
        checkOutput("f1_start", conv_start, 1'b1);

        // Hold in CONV for 50 cycles with beats offered on both ports.
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 16'hdead, 1'b1, 16'hbeef, 1'b0);
            checkOutput("conv_hold_start", conv_start, 1'b1);
            checkIdle("conv_hold");
            step();
        end

        // Turnaround: conv_done sampled on this edge.
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        checkOutput("turn_pre_start", conv_start, 1'b1);
        step();

        // Frame 2: gapped valids, stray conv_done, simultaneous finish.
        $display("[TB] frame 2: gaps and simultaneous finish");
        x_sent   = 0;
        f_sent   = 0;
        x_writes = 0;
        f_writes = 0;
        c        = 0;
        while (x_sent < N && c < 300) begin
            vx = (x_sent < N - 1) ? (c % 3 != 2) : (f_sent == M - 1);
            vf = (f_sent < M - 1) ? (c % 4 == 1) : (f_sent == M - 1 && x_sent == N - 1);
            applyStimulus(vx, T'(16'h3000 + x_sent), vf, T'(16'h4000 + f_sent), c == 5);
            if (c == 0) begin
                checkOutput("turn_start_low", conv_start, 1'b0);
                checkOutput("turn_rdy_x", s_ready_x, 1'b1);
                checkOutput("turn_rdy_f", s_ready_f, 1'b1);
                checkOutput("turn_x_addr0", xmem_wr_addr, 0);
            end
            checkOutput("f2_x_wen", xmem_wr_en, vx);
            checkOutput("f2_f_wen", fmem_wr_en, vf);
            if (vx) begin
                checkOutput("f2_x_addr", xmem_wr_addr, x_sent);
                checkOutput("f2_x_data", xmem_wr_data, 16'h3000 + x_sent);
            end
            if (vf) begin
                checkOutput("f2_f_addr", fmem_wr_addr, f_sent);
                checkOutput("f2_f_data", fmem_wr_data, 16'h4000 + f_sent);
            end
            checkOutput("f2_start_low", conv_start, 1'b0);
            if (xmem_wr_en) x_writes++;
            if (fmem_wr_en) f_writes++;
            if (vx) x_sent++;
            if (vf) f_sent++;
            c++;
            step();
        end
        checkOutput("f2_bound", x_sent, N);
        applyStimulus(1'b1, 16'h0, 1'b1, 16'h0, 1'b0);
        checkOutput("f2_sim_start", conv_start, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h0, 1'b1, 16'h0, 1'b0);
            if (xmem_wr_en) x_writes++;
            if (fmem_wr_en) f_writes++;
            checkIdle("f2_conv");
            step();
        end
        checkOutput("f2_x_writes", x_writes, N);
        checkOutput("f2_f_writes", f_writes, M);

        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        step();

        // Frame 3: reset after 12 x beats and 4 f beats.
        $display("[TB] frame 3: reset during LOAD");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, T'(16'h5000 + i), i < 4, T'(16'h6000 + i), 1'b0);
            checkOutput("f3_x_addr", xmem_wr_addr, i);
            checkOutput("f3_f_wen", fmem_wr_en, i < 4);
            step();
        end
        applyStimulus(1'b1, 16'h0, 1'b1, 16'h0, 1'b0);
        checkOutput("f3_pre_rdy_x", s_ready_x, 1'b1);
        checkOutput("f3_pre_f_addr", fmem_wr_addr, 4);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("f3_rst_start", conv_start, 1'b0);
        checkIdle("f3_rst");
        step();
        reset_n = 1'b1;
        step();

        // Frame 4 restarts at address 0 and reaches CONV.
        $display("[TB] frame 4: restart after reset");
        fullRateFrame("f4");
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("f4_start", conv_start, 1'b1);

        // Reset in CONV must drop conv_start with no clock edge.
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("conv_rst_start", conv_start, 1'b0);
        checkIdle("conv_rst");
        step();
        reset_n = 1'b1;
        step();
        applyStimulus(1'b1, 16'h7777, 1'b1, 16'h8888, 1'b0);
        checkOutput("post_rst_x_wen", xmem_wr_en, 1'b1);
        checkOutput("post_rst_x_addr", xmem_wr_addr, 0);
        checkOutput("post_rst_f_addr", fmem_wr_addr, 0);
        step();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        checkOutput("post_rst_x_addr1", xmem_wr_addr, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
